// File: rtl/biriscv_vec_sequencer_if.sv
// -----------------------------------------------------------------------------
// biriscv_vec_sequencer_if
// Purpose : groups the issue handshake, flush and lane-beat handshake of the
//           vector sequencer into one bundle.
// Modports:
//   master - issue/lane environment: drives issue_*, flush_i, lane_ready_i;
//            observes accept, lane beat fields, busy and done.
//   slave  - the sequencer itself (reverse directions).
// Signals : issue_valid_i/issue_opcode_i[31:0]/issue_vl_i[4:0]/issue_accept_o,
//           flush_i, lane_valid_o/lane_ready_i, lane_vd_o/lane_vs1_o/
//           lane_vs2_o[4:0], lane_vm_o, lane_elem_idx_o[3:0],
//           lane_mask_o[LANES-1:0], busy_o, done_o.
// -----------------------------------------------------------------------------
interface biriscv_vec_sequencer_if #(
    parameter int unsigned LANES = 4
);
    logic             issue_valid_i;
    logic [31:0]      issue_opcode_i;
    logic [4:0]       issue_vl_i;
    logic             issue_accept_o;
    logic             flush_i;
    logic             lane_valid_o;
    logic             lane_ready_i;
    logic [4:0]       lane_vd_o;
    logic [4:0]       lane_vs1_o;
    logic [4:0]       lane_vs2_o;
    logic             lane_vm_o;
    logic [3:0]       lane_elem_idx_o;
    logic [LANES-1:0] lane_mask_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output issue_valid_i, issue_opcode_i, issue_vl_i, flush_i, lane_ready_i,
        input  issue_accept_o, lane_valid_o, lane_vd_o, lane_vs1_o, lane_vs2_o,
               lane_vm_o, lane_elem_idx_o, lane_mask_o, busy_o, done_o
    );

    modport slave (
        input  issue_valid_i, issue_opcode_i, issue_vl_i, flush_i, lane_ready_i,
        output issue_accept_o, lane_valid_o, lane_vd_o, lane_vs1_o, lane_vs2_o,
               lane_vm_o, lane_elem_idx_o, lane_mask_o, busy_o, done_o
    );
endinterface

// File: rtl/biriscv_vec_sequencer.sv
// -----------------------------------------------------------------------------
// biriscv_vec_sequencer
// Purpose : accepts one decoded vector instruction at a time and splits it into
//           ceil(vl/LANES) lane beats, each carrying the register indices, the
//           first element index and a per-lane active mask; pulses done_o one
//           cycle after the last beat is taken by the lane datapath.
// Ports   : clk_i      - clock, rising edge
//           rst_i      - synchronous active-low reset
//           bus        - biriscv_vec_sequencer_if.slave (issue/lane/flush/status)
//           perf_beats_o[31:0] - lane handshake count (only with
//                        BIRISCV_VEC_PERF_EN defined)
// Options : `define BIRISCV_VEC_PERF_EN adds the perf_beats_o counter.
// -----------------------------------------------------------------------------
module biriscv_vec_sequencer #(
    parameter int unsigned LANES = 4,
    parameter int unsigned VLMAX = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
`ifdef BIRISCV_VEC_PERF_EN
    output logic [31:0]            perf_beats_o,
`endif
    biriscv_vec_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] VLMAX_W = 5'(VLMAX);
    localparam logic [4:0] LANES_W = 5'(LANES);

    state_t     state_q;
    state_t     state_d;
    logic [4:0] vd_q;
    logic [4:0] vs1_q;
    logic [4:0] vs2_q;
    logic       vm_q;
    logic [4:0] vl_q;
    logic [4:0] idx_q;
    logic [4:0] vl_in;
    logic       accept;
    logic       handshake;
    logic       last_beat;
    logic       opcode_unused;

    // Opcode bits that carry no information for sequencing.
    assign opcode_unused = ^{bus.issue_opcode_i[31:26], bus.issue_opcode_i[14:12],
                             bus.issue_opcode_i[6:0]};

    assign vl_in     = (bus.issue_vl_i > VLMAX_W) ? VLMAX_W : bus.issue_vl_i;
    // Gated by rst_i so nothing is reported as accepted while reset is held.
    assign accept    = rst_i && (state_q == IDLE) && bus.issue_valid_i && !bus.flush_i;
    assign handshake = (state_q == RUN) && bus.lane_ready_i;
    // idx_q holds b*LANES; the beat is last once it covers element vl-1.
    assign last_beat = (idx_q + LANES_W) >= vl_q;

    assign bus.issue_accept_o  = accept;
    assign bus.lane_vd_o       = vd_q;
    assign bus.lane_vs1_o      = vs1_q;
    assign bus.lane_vs2_o      = vs2_q;
    assign bus.lane_vm_o       = vm_q;
    assign bus.lane_elem_idx_o = idx_q[3:0];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.lane_valid_o = 1'b0;
        bus.lane_mask_o  = '0;
        bus.busy_o       = 1'b0;
        bus.done_o       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (vl_in == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                bus.lane_valid_o = 1'b1;
                bus.busy_o       = 1'b1;
                for (int unsigned i = 0; i < LANES; i++) begin
                    bus.lane_mask_o[i] = (idx_q + 5'(i)) < vl_q;
                end
                // A handshake coinciding with flush is consumed but never completes.
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else if (handshake && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.busy_o = 1'b1;
                bus.done_o = !bus.flush_i;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            vd_q  <= '0;
            vs1_q <= '0;
            vs2_q <= '0;
            vm_q  <= 1'b0;
            vl_q  <= '0;
            idx_q <= '0;
        end else if (accept) begin
            vd_q  <= bus.issue_opcode_i[11:7];
            vs1_q <= bus.issue_opcode_i[19:15];
            vs2_q <= bus.issue_opcode_i[24:20];
            vm_q  <= bus.issue_opcode_i[25];
            vl_q  <= vl_in;
            idx_q <= '0;
        end else if (handshake) begin
            idx_q <= idx_q + LANES_W;
        end
    end

`ifdef BIRISCV_VEC_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            perf_beats_o <= '0;
        end else if (handshake) begin
            perf_beats_o <= perf_beats_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_biriscv_vec_sequencer.sv
module tb_biriscv_vec_sequencer;
    localparam int unsigned LANES = 4;
    localparam int unsigned VLMAX = 16;
    localparam int unsigned BUDGET = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    biriscv_vec_sequencer_if #(.LANES(LANES)) bus ();

`ifdef BIRISCV_VEC_PERF_EN
    logic [31:0] perf_beats;
`endif

    biriscv_vec_sequencer #(
        .LANES(LANES),
        .VLMAX(VLMAX)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
`ifdef BIRISCV_VEC_PERF_EN
        .perf_beats_o(perf_beats),
`endif
        .bus         (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int unsigned perf_m = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_perf(input string tag);
`ifdef BIRISCV_VEC_PERF_EN
        chk(tag, perf_beats, perf_m);
`endif
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_lane_valid"}, 32'(bus.lane_valid_o), 0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 0);
        chk({tag, "_done"}, 32'(bus.done_o), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_idle(tag);
        chk({tag, "_accept"}, 32'(bus.issue_accept_o), 0);
        chk({tag, "_vd"}, 32'(bus.lane_vd_o), 0);
        chk({tag, "_vs1"}, 32'(bus.lane_vs1_o), 0);
        chk({tag, "_vs2"}, 32'(bus.lane_vs2_o), 0);
        chk({tag, "_vm"}, 32'(bus.lane_vm_o), 0);
        chk({tag, "_idx"}, 32'(bus.lane_elem_idx_o), 0);
        chk({tag, "_mask"}, 32'(bus.lane_mask_o), 0);
        chk_perf({tag, "_perf"});
    endtask

    // Starts at a negedge with the sequencer idle; returns at a negedge with it idle.
    task automatic run_instr(input logic [31:0] op, input logic [4:0] vl_req,
                             input int unsigned ready_pct, input int stall_beat,
                             input int unsigned stall_cycles, input int flush_beat);
        int unsigned      vl_e;
        int unsigned      nbeats;
        int unsigned      b;
        int unsigned      stall_cnt;
        int unsigned      cyc;
        logic [LANES-1:0] mexp;
        logic             rdy;
        logic             fl;

        vl_e   = (int'(vl_req) > int'(VLMAX)) ? VLMAX : 32'(vl_req);
        nbeats = (vl_e + LANES - 1) / LANES;

        bus.issue_valid_i  = 1'b1;
        bus.issue_opcode_i = op;
        bus.issue_vl_i     = vl_req;
        bus.flush_i        = 1'b0;
        bus.lane_ready_i   = 1'b0;
        #1;
        chk("accept", 32'(bus.issue_accept_o), 1);
        chk("busy_before_accept", 32'(bus.busy_o), 0);
        @(negedge clk);
        bus.issue_valid_i = 1'($urandom_range(0, 1));
        bus.issue_vl_i    = 5'($urandom);

        if (nbeats == 0) begin
            #1;
            chk("zero_done", 32'(bus.done_o), 1);
            chk("zero_busy", 32'(bus.busy_o), 1);
            chk("zero_lane_valid", 32'(bus.lane_valid_o), 0);
            chk("zero_accept_ignored", 32'(bus.issue_accept_o), 0);
            @(negedge clk);
            bus.issue_valid_i = 1'b0;
            #1;
            chk_idle("zero_after");
            chk_perf("zero_perf");
            return;
        end

        b         = 0;
        stall_cnt = 0;
        cyc       = 0;
        while (b < nbeats) begin
            if (cyc > BUDGET) begin
                chk("beat_timeout", 32'(cyc <= BUDGET), 1);
                return;
            end
            if (int'(b) == stall_beat && stall_cnt < stall_cycles) begin
                rdy = 1'b0;
                stall_cnt++;
            end else begin
                rdy = ($urandom_range(0, 99) < ready_pct);
            end
            fl = (int'(b) == flush_beat);
            bus.lane_ready_i  = rdy;
            bus.flush_i       = fl;
            bus.issue_valid_i = 1'($urandom_range(0, 1));
            for (int unsigned i = 0; i < LANES; i++) begin
                mexp[i] = (b * LANES + i) < vl_e;
            end
            #1;
            chk("lane_valid", 32'(bus.lane_valid_o), 1);
            chk("elem_idx", 32'(bus.lane_elem_idx_o), b * LANES);
            chk("mask", 32'(bus.lane_mask_o), 32'(mexp));
            chk("vd", 32'(bus.lane_vd_o), 32'(op[11:7]));
            chk("vs1", 32'(bus.lane_vs1_o), 32'(op[19:15]));
            chk("vs2", 32'(bus.lane_vs2_o), 32'(op[24:20]));
            chk("vm", 32'(bus.lane_vm_o), 32'(op[25]));
            chk("run_done", 32'(bus.done_o), 0);
            chk("run_busy", 32'(bus.busy_o), 1);
            chk("run_accept_ignored", 32'(bus.issue_accept_o), 0);
            cyc++;
            if (rdy) perf_m++;
            @(negedge clk);
            if (fl) begin
                bus.flush_i       = 1'b0;
                bus.lane_ready_i  = 1'b0;
                bus.issue_valid_i = 1'b0;
                #1;
                chk_idle("flush_after");
                chk_perf("flush_perf");
                return;
            end
            if (rdy) b++;
        end

        bus.lane_ready_i  = 1'($urandom_range(0, 1));
        bus.issue_valid_i = 1'($urandom_range(0, 1));
        #1;
        chk("done_pulse", 32'(bus.done_o), 1);
        chk("done_lane_valid", 32'(bus.lane_valid_o), 0);
        chk("done_busy", 32'(bus.busy_o), 1);
        chk("done_accept_ignored", 32'(bus.issue_accept_o), 0);
        if (ready_pct == 100) chk("run_cycles", cyc, nbeats + stall_cnt);
        @(negedge clk);
        bus.issue_valid_i = 1'b0;
        bus.lane_ready_i  = 1'b0;
        #1;
        chk_idle("done_after");
        chk_perf("done_perf");
    endtask

    task automatic reset_mid_run(input logic [31:0] op);
        bus.issue_valid_i  = 1'b1;
        bus.issue_opcode_i = op;
        bus.issue_vl_i     = 5'd12;
        bus.flush_i        = 1'b0;
        bus.lane_ready_i   = 1'b0;
        #1;
        chk("rst_accept", 32'(bus.issue_accept_o), 1);
        @(negedge clk);
        bus.issue_valid_i = 1'b0;
        bus.lane_ready_i  = 1'b1;
        #1;
        chk("rst_beat0_valid", 32'(bus.lane_valid_o), 1);
        perf_m++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_beat1_idx", 32'(bus.lane_elem_idx_o), LANES);
        @(negedge clk);
        rst              = 1'b1;
        bus.lane_ready_i = 1'b0;
        perf_m           = 0;
        #1;
        chk_all_zero("rst_mid_run");
        @(negedge clk);
        #1;
        chk_all_zero("rst_no_done");
    endtask

    logic [31:0] op_r;
    logic [4:0]  vl_r;
    int          fb;

    initial begin
        rst                = 1'b0;
        bus.issue_valid_i  = 1'b1;
        bus.issue_opcode_i = $urandom;
        bus.issue_vl_i     = 5'd7;
        bus.flush_i        = 1'b0;
        bus.lane_ready_i   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_all_zero("in_reset");
        rst               = 1'b1;
        bus.issue_valid_i = 1'b0;
        bus.lane_ready_i  = 1'b0;
        @(negedge clk);
        #1;
        chk_all_zero("after_reset");
        @(negedge clk);

        // vl=10, always ready: idx 0/4/8, masks 1111/1111/0011
        run_instr($urandom, 5'd10, 100, -1, 0, -1);
        // vl=8 with beat 1 stalled for 3 cycles
        run_instr($urandom, 5'd8, 100, 1, 3, -1);
        // vl=0: straight to completion
        run_instr($urandom, 5'd0, 100, -1, 0, -1);
        // vl clamps to VLMAX
        run_instr($urandom, 5'd20, 100, -1, 0, -1);
        run_instr($urandom, 5'd31, 100, -1, 0, -1);
        // vl=12 flushed on beat 1, new issue accepted right after
        run_instr($urandom, 5'd12, 100, -1, 0, 1);
        run_instr($urandom, 5'd5, 100, -1, 0, -1);
        // reset while running
        reset_mid_run($urandom);

        for (int n = 0; n < 40; n++) begin
            op_r = $urandom;
            vl_r = 5'($urandom);
            fb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_instr(op_r, vl_r, 70, int'($urandom_range(0, 3)), $urandom_range(0, 2), fb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
